// File: rtl/grey_colorize_pkg.sv
// Shared definitions for the greyscale colouriser: tint indices, the fixed
// RGB coefficient triples and the coefficient selection helper.
package grey_colorize_pkg;

  typedef enum logic [1:0] {
    TINT_WHITE  = 2'd0,
    TINT_GREEN  = 2'd1,
    TINT_AMBER  = 2'd2,
    TINT_CUSTOM = 2'd3
  } tint_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t WHITE_RGB = {8'd255, 8'd255, 8'd255};
  localparam rgb_t GREEN_RGB = {8'd51,  8'd255, 8'd51};
  localparam rgb_t AMBER_RGB = {8'd255, 8'd176, 8'd0};

  // Map a tint index to its coefficient triple; custom comes from the
  // currently active custom registers.
  function automatic rgb_t tint_coeff(input logic [1:0] sel, input rgb_t custom);
    rgb_t c;
    case (sel)
      TINT_WHITE: c = WHITE_RGB;
      TINT_GREEN: c = GREEN_RGB;
      TINT_AMBER: c = AMBER_RGB;
      default:    c = custom;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/grey_colorize_if.sv
// Pixel stream and tint control bundle for the greyscale colouriser.
// Optional macro GREY_COLORIZE_SCANLINE_EN adds the scanline enable signal.
interface grey_colorize_if;
  logic       ce;
  logic [7:0] luma;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [1:0] tint_sel;
  logic       tint_wr;
  logic [7:0] tint_r;
  logic [7:0] tint_g;
  logic [7:0] tint_b;
`ifdef GREY_COLORIZE_SCANLINE_EN
  logic       scanline;
`endif
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hs_out;
  logic       vs_out;
  logic       blank_out;
  logic       tint_pend;

  // Source side: drives pixels and tint control, receives colour.
  modport master (
    output ce, luma, hs, vs, blank, tint_sel, tint_wr, tint_r, tint_g, tint_b,
`ifdef GREY_COLORIZE_SCANLINE_EN
    output scanline,
`endif
    input  r, g, b, hs_out, vs_out, blank_out, tint_pend
  );

  // Colouriser side.
  modport slave (
    input  ce, luma, hs, vs, blank, tint_sel, tint_wr, tint_r, tint_g, tint_b,
`ifdef GREY_COLORIZE_SCANLINE_EN
    input  scanline,
`endif
    output r, g, b, hs_out, vs_out, blank_out, tint_pend
  );
endinterface

// File: rtl/grey_chan_mul.sv
// One colour channel: (luma * (coeff + 1)) >> 8, registered as pipeline
// stage 2, with blank forcing and an optional halving for scanlines.
module grey_chan_mul (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ce,
  input  logic [7:0] i_luma,
  input  logic [7:0] i_coeff,
  input  logic       i_blank,
  input  logic       i_half,
  output logic [7:0] o_chan
);

  logic [16:0] prod;
  logic [7:0]  scaled;
  logic [7:0]  chan_d;
  logic [7:0]  chan_q;

  // coeff + 1 makes 255 an exact unity gain and 0 still yields 0.
  always_comb begin
    prod   = 17'(i_luma) * (17'(i_coeff) + 17'd1);
    scaled = 8'(prod >> 8);
    chan_d = i_half ? (scaled >> 1) : scaled;
    if (i_blank) chan_d = 8'd0;
  end

  // Stage-2 product register, held while the pixel enable is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  chan_q <= 8'd0;
    else if (i_ce) chan_q <= chan_d;
  end

  assign o_chan = chan_q;

endmodule

// File: rtl/grey_colorize.sv
// Greyscale-to-colour tint stage with frame-synchronous tint switching.
// Two-stage pipeline: stage 1 captures luma/sync/blank and coefficients,
// stage 2 captures the per-channel products.
// Optional macro GREY_COLORIZE_SCANLINE_EN adds i_scanline and line parity.
module grey_colorize
  import grey_colorize_pkg::*;
#(
  parameter logic [1:0] RESET_TINT = 2'd0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ce,
  input  logic [7:0] i_luma,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_blank,
  input  logic [1:0] i_tint_sel,
  input  logic       i_tint_wr,
  input  logic [7:0] i_tint_r,
  input  logic [7:0] i_tint_g,
  input  logic [7:0] i_tint_b,
`ifdef GREY_COLORIZE_SCANLINE_EN
  input  logic       i_scanline,
`endif
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_blank,
  output logic       o_tint_pend
);

  // ---------------- tint control ----------------
  logic [1:0] act_sel_q, act_sel_d;
  rgb_t       act_cust_q, act_cust_d;
  rgb_t       pend_cust_q, pend_cust_d;
  logic       pend_q, pend_d;
  logic       vs_prev_q, vs_prev_d;
  logic       frame_edge;

  assign frame_edge = i_ce & i_vs & ~vs_prev_q;

  // Boundary applies the old pending value; a coinciding write is queued
  // for the following boundary because it is evaluated last.
  always_comb begin
    act_sel_d   = act_sel_q;
    act_cust_d  = act_cust_q;
    pend_cust_d = pend_cust_q;
    pend_d      = pend_q;
    vs_prev_d   = vs_prev_q;
    if (i_ce) vs_prev_d = i_vs;
    if (frame_edge) begin
      act_sel_d  = i_tint_sel;
      act_cust_d = pend_cust_q;
      pend_d     = 1'b0;
    end
    if (i_tint_wr) begin
      pend_cust_d = {i_tint_r, i_tint_g, i_tint_b};
      pend_d      = 1'b1;
    end
  end

  // Tint state registers; the write strobe is not gated by i_ce.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_sel_q   <= RESET_TINT;
      act_cust_q  <= '1;
      pend_cust_q <= '1;
      pend_q      <= 1'b0;
      vs_prev_q   <= 1'b0;
    end else begin
      act_sel_q   <= act_sel_d;
      act_cust_q  <= act_cust_d;
      pend_cust_q <= pend_cust_d;
      pend_q      <= pend_d;
      vs_prev_q   <= vs_prev_d;
    end
  end

  // Pending indicator is forced low while reset is asserted.
  assign o_tint_pend = i_rst_n & (pend_q | (i_tint_sel != act_sel_q));

  // ---------------- scanline parity ----------------
  logic half_s1;
`ifdef GREY_COLORIZE_SCANLINE_EN
  logic hs_prev_q;
  logic par_q, par_d;
  logic half_q1;

  // Parity flips on each hs rise and restarts at every frame.
  always_comb begin
    par_d = par_q;
    if (i_ce) begin
      if (frame_edge)              par_d = 1'b0;
      else if (i_hs && !hs_prev_q) par_d = ~par_q;
    end
  end

  // Line parity state and the per-pixel halving flag for stage 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_prev_q <= 1'b0;
      par_q     <= 1'b0;
      half_q1   <= 1'b0;
    end else begin
      par_q <= par_d;
      if (i_ce) begin
        hs_prev_q <= i_hs;
        half_q1   <= i_scanline & par_d;
      end
    end
  end

  assign half_s1 = half_q1;
`else
  assign half_s1 = 1'b0;
`endif

  // ---------------- stage 1 ----------------
  logic [7:0] luma_q1;
  logic       hs_q1, vs_q1, blank_q1;
  rgb_t       coef_q1;

  // Capture pixel, sync and the coefficients of the active tint.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      luma_q1  <= 8'd0;
      hs_q1    <= 1'b0;
      vs_q1    <= 1'b0;
      blank_q1 <= 1'b0;
      coef_q1  <= '0;
    end else if (i_ce) begin
      luma_q1  <= i_luma;
      hs_q1    <= i_hs;
      vs_q1    <= i_vs;
      blank_q1 <= i_blank;
      coef_q1  <= tint_coeff(act_sel_q, act_cust_q);
    end
  end

  // ---------------- stage 2 ----------------
  logic hs_q2, vs_q2, blank_q2;

  // Sync/blank delayed alongside the channel product registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_q2    <= 1'b0;
      vs_q2    <= 1'b0;
      blank_q2 <= 1'b0;
    end else if (i_ce) begin
      hs_q2    <= hs_q1;
      vs_q2    <= vs_q1;
      blank_q2 <= blank_q1;
    end
  end

  logic [2:0][7:0] coef_v;
  logic [2:0][7:0] chan_v;

  assign coef_v = coef_q1;   // [2]=r, [1]=g, [0]=b

  for (genvar c = 0; c < 3; c++) begin : g_chan
    grey_chan_mul u_mul (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ce    (i_ce),
      .i_luma  (luma_q1),
      .i_coeff (coef_v[c]),
      .i_blank (blank_q1),
      .i_half  (half_s1),
      .o_chan  (chan_v[c])
    );
  end

  assign o_r     = chan_v[2];
  assign o_g     = chan_v[1];
  assign o_b     = chan_v[0];
  assign o_hs    = hs_q2;
  assign o_vs    = vs_q2;
  assign o_blank = blank_q2;

endmodule

// File: tb/tb_grey_colorize.sv
// Directed bench for grey_colorize: tint table, latency, custom tint timing,
// clock-enable stalls and asynchronous reset (plus scanline when enabled).
module tb_grey_colorize;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  grey_colorize_if pix();

  always #5 clk = ~clk;

  grey_colorize #(.RESET_TINT(2'd0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ce       (pix.ce),
    .i_luma     (pix.luma),
    .i_hs       (pix.hs),
    .i_vs       (pix.vs),
    .i_blank    (pix.blank),
    .i_tint_sel (pix.tint_sel),
    .i_tint_wr  (pix.tint_wr),
    .i_tint_r   (pix.tint_r),
    .i_tint_g   (pix.tint_g),
    .i_tint_b   (pix.tint_b),
`ifdef GREY_COLORIZE_SCANLINE_EN
    .i_scanline (pix.scanline),
`endif
    .o_r        (pix.r),
    .o_g        (pix.g),
    .o_b        (pix.b),
    .o_hs       (pix.hs_out),
    .o_vs       (pix.vs_out),
    .o_blank    (pix.blank_out),
    .o_tint_pend(pix.tint_pend)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  luma;
    logic        blank;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic frame_edge();
    pix.vs = 1'b1;
    tick();
    pix.vs = 1'b0;
    tick();
  endtask

  task automatic wr_tint(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pix.tint_r  = r;
    pix.tint_g  = g;
    pix.tint_b  = b;
    pix.tint_wr = 1'b1;
  endtask

  function automatic logic [23:0] rgb();
    return {pix.r, pix.g, pix.b};
  endfunction

  initial begin
    vecs[0] = '{2'd0, 8'd200, 1'b0, 24'hC8C8C8};
    vecs[1] = '{2'd0, 8'd0,   1'b0, 24'h000000};
    vecs[2] = '{2'd0, 8'd255, 1'b0, 24'hFFFFFF};
    vecs[3] = '{2'd1, 8'd100, 1'b0, {8'd20, 8'd100, 8'd20}};
    vecs[4] = '{2'd1, 8'd255, 1'b0, {8'd51, 8'd255, 8'd51}};
    vecs[5] = '{2'd2, 8'd255, 1'b0, {8'd255, 8'd176, 8'd0}};
    vecs[6] = '{2'd2, 8'd128, 1'b0, {8'd128, 8'd88, 8'd0}};
    vecs[7] = '{2'd2, 8'd1,   1'b0, {8'd1, 8'd0, 8'd0}};
    vecs[8] = '{2'd0, 8'd255, 1'b1, 24'h000000};
    vecs[9] = '{2'd3, 8'd100, 1'b0, {8'd100, 8'd100, 8'd100}};

    rst_n = 1'b0;
    pix.ce = 1'b1; pix.luma = 8'd0; pix.hs = 1'b0; pix.vs = 1'b0; pix.blank = 1'b0;
    pix.tint_sel = 2'd0; pix.tint_wr = 1'b0;
    pix.tint_r = 8'd0; pix.tint_g = 8'd0; pix.tint_b = 8'd0;
`ifdef GREY_COLORIZE_SCANLINE_EN
    pix.scanline = 1'b0;
`endif
    #12;
    chk("reset_outs", {rgb(), pix.hs_out, pix.vs_out, pix.blank_out}, 0);
    chk("reset_pend", pix.tint_pend, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick(); tick();

    // Latency: white, luma 200 with hs/vs raised together.
    pix.luma = 8'd200; pix.hs = 1'b1; pix.vs = 1'b1;
    tick();
    chk("lat1_rgb", rgb(), 0);
    chk("lat1_sync", {pix.hs_out, pix.vs_out}, 2'b00);
    tick();
    chk("lat2_rgb", rgb(), 24'hC8C8C8);
    chk("lat2_sync", {pix.hs_out, pix.vs_out}, 2'b11);
    pix.hs = 1'b0; pix.vs = 1'b0;
    tick();

    // Tint table: select, cross a frame boundary, then check a pixel.
    for (int i = 0; i < 10; i++) begin
      pix.tint_sel = vecs[i].sel;
      frame_edge();
      pix.luma  = vecs[i].luma;
      pix.blank = vecs[i].blank;
      tick(); tick();
      chk($sformatf("vec%0d_rgb", i), rgb(), vecs[i].exp_rgb);
      chk($sformatf("vec%0d_blank", i), pix.blank_out, vecs[i].blank);
      chk($sformatf("vec%0d_pend", i), pix.tint_pend, 0);
      pix.blank = 1'b0;
    end

    // Mid-frame custom write waits for the frame boundary.
    pix.tint_sel = 2'd3;
    frame_edge();
    pix.luma = 8'd255;
    tick(); tick();
    chk("cw_before", rgb(), 24'hFFFFFF);
    wr_tint(8'd10, 8'd20, 8'd30);
    tick();
    pix.tint_wr = 1'b0;
    chk("cw_pend", pix.tint_pend, 1);
    tick(); tick();
    chk("cw_hold", rgb(), 24'hFFFFFF);
    pix.vs = 1'b1;
    tick();
    pix.vs = 1'b0;
    chk("cw_pend_clr", pix.tint_pend, 0);
    tick(); tick();
    chk("cw_apply", rgb(), {8'd10, 8'd20, 8'd30});

    // Selection change mid-frame is only flagged, not applied.
    pix.tint_sel = 2'd0;
    tick();
    chk("sel_pend", pix.tint_pend, 1);
    tick();
    chk("sel_hold", rgb(), {8'd10, 8'd20, 8'd30});
    pix.tint_sel = 2'd3;
    tick();
    chk("sel_back", pix.tint_pend, 0);

    // Write coinciding with a boundary stays pending; old pending applies.
    wr_tint(8'd1, 8'd2, 8'd3);
    tick();
    wr_tint(8'd200, 8'd200, 8'd200);
    pix.vs = 1'b1;
    tick();
    pix.tint_wr = 1'b0; pix.vs = 1'b0;
    chk("co_pend", pix.tint_pend, 1);
    tick(); tick();
    chk("co_old", rgb(), {8'd1, 8'd2, 8'd3});
    frame_edge();
    tick(); tick();
    chk("co_new", rgb(), 24'hC8C8C8);
    chk("co_pend_clr", pix.tint_pend, 0);

    // Clock-enable stalls: one enable every third cycle.
    pix.tint_sel = 2'd0;
    frame_edge();
    pix.luma = 8'd30;
    tick(); tick(); tick();
    chk("ce_pre", pix.r, 30);
    pix.luma = 8'd50;
    tick();
    pix.ce = 1'b0; pix.luma = 8'd77;
    tick();
    chk("ce_hold1", pix.r, 30);
    tick();
    chk("ce_hold2", pix.r, 30);
    pix.ce = 1'b1; pix.luma = 8'd90;
    tick();
    chk("ce_out50", pix.r, 50);
    pix.ce = 1'b0; pix.luma = 8'd11;
    tick();
    chk("ce_hold3", pix.r, 50);
    tick();
    chk("ce_hold4", pix.r, 50);
    pix.ce = 1'b1; pix.luma = 8'd90;
    tick();
    chk("ce_out90", pix.r, 90);

    // Asynchronous reset mid-line while amber is active.
    pix.tint_sel = 2'd2;
    frame_edge();
    pix.luma = 8'd200; pix.hs = 1'b1;
    tick(); tick();
    chk("pre_rst", rgb(), {8'd200, 8'd138, 8'd0});
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {rgb(), pix.hs_out, pix.vs_out, pix.blank_out}, 0);
    chk("rst_async_pend", pix.tint_pend, 0);
    pix.hs = 1'b0;
`ifdef GREY_COLORIZE_SCANLINE_EN
    pix.scanline = 1'b1;
`endif
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_sel_pend", pix.tint_pend, 1);
    tick(); tick();
    chk("rst_tint", rgb(), 24'hC8C8C8);
`ifdef GREY_COLORIZE_SCANLINE_EN
    pix.hs = 1'b1;
    tick();
    pix.hs = 1'b0;
    tick(); tick();
    chk("scan_line1", rgb(), 24'h646464);
    pix.scanline = 1'b0;
`endif
    frame_edge();
    tick(); tick();
    chk("rst_then_amber", rgb(), {8'd200, 8'd138, 8'd0});
    chk("rst_then_pend", pix.tint_pend, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grey_colorize.md
GREY_COLORIZE -- requirements
Module: grey_colorize

Interface
REQ-001 SHALL have parameter RESET_TINT, default 2'd0, which selects the tint active after reset.
REQ-002 SHALL have port i_clk, input, 1 bit: the single system clock.
REQ-003 SHALL have port i_rst_n, input, 1 bit: the only reset, asynchronous and active-low.
REQ-004 SHALL have port i_ce, input, 1 bit: pixel clock enable; pipeline and all state advance only when it is 1.
REQ-005 SHALL have port i_luma, input, 8 bits: grey level, 0 = black, 255 = full.
REQ-006 SHALL have ports i_hs, i_vs and i_blank, input, 1 bit each: sync and blank aligned with i_luma.
REQ-007 SHALL have port i_tint_sel, input, 2 bits: requested tint (0 white, 1 green, 2 amber, 3 custom).
REQ-008 SHALL have port i_tint_wr, input, 1 bit: write strobe, sampled on i_clk and independent of i_ce.
REQ-009 SHALL have ports i_tint_r, i_tint_g and i_tint_b, input, 8 bits each: custom tint coefficients.
REQ-010 SHALL have ports o_r, o_g and o_b, output, 8 bits each: colourised pixel.
REQ-011 SHALL have ports o_hs, o_vs and o_blank, output, 1 bit each: the inputs delayed to match o_r, o_g and o_b.
REQ-012 SHALL have port o_tint_pend, output, 1 bit: 1 while a custom-tint or selection change waits for the frame boundary.

Function
REQ-013 SHALL compute each channel as (i_luma * (coeff + 1)) >> 8, using an unsigned 17-bit product truncated to 8 bits.
REQ-014 SHALL make coeff 255 pass luma unchanged and coeff 0 give 0.
REQ-015 SHALL use these fixed tints: white (255,255,255), green (51,255,51), amber (255,176,0).
REQ-016 SHALL take the custom tint from the active custom registers.
REQ-017 SHALL have a latency of exactly 2 i_ce cycles from inputs to outputs.
- Stage 1 registers luma, sync and blank, and the selected coefficients.
- Stage 2 registers the products.
REQ-018 SHALL hold all registers while i_ce = 0.
REQ-019 SHALL force o_r, o_g and o_b to 0 whenever the delayed blank is 1; o_hs and o_vs still pass through.
REQ-020 SHALL load i_tint_r, i_tint_g and i_tint_b into pending custom registers on i_tint_wr = 1 and set the pending flag.
REQ-021 SHALL apply the last write when several writes occur in one frame.
REQ-022 SHALL detect the frame boundary as a rising edge of i_vs, sampled on i_ce cycles against a registered previous value.
REQ-023 SHALL, at the frame boundary:
- copy i_tint_sel into the active selection;
- copy the pending custom registers into the active registers;
- clear the pending flag.
REQ-024 SHALL drive o_tint_pend = 1 whenever the pending flag is set or i_tint_sel differs from the active selection.
REQ-025 SHALL, when i_tint_wr coincides with a frame boundary, latch the new value into pending, leave it pending for the next boundary, and apply the old pending value now.
REQ-026 SHALL ignore changes to i_tint_sel mid-frame until the next boundary.

Reset
REQ-027 SHALL, while i_rst_n = 0, asynchronously clear:
- all pipeline registers;
- o_r, o_g and o_b;
- o_hs, o_vs and o_blank;
- o_tint_pend and the previous-vs register.
REQ-028 SHALL reset the active selection to RESET_TINT and the active and pending custom registers to 8'hFF.
REQ-029 SHALL, after a reset deasserted mid-frame, keep the RESET_TINT tint until the first i_vs rising edge.

Configuration
REQ-030 SHALL compile in scanline emulation when macro GREY_COLORIZE_SCANLINE_EN is defined.
- A 1-bit line parity toggles on each i_hs rising edge (on i_ce cycles) and clears on the frame boundary.
- An added input port i_scanline (1 bit) enables the effect.
- When i_scanline = 1 and parity = 1, each stage-2 channel is shifted right by 1.
- Latency stays 2.
REQ-031 SHALL, when GREY_COLORIZE_SCANLINE_EN is undefined, have no i_scanline port, no parity register, and an output identical to the enabled build with i_scanline = 0.

Structure
REQ-032 SHALL place the tint index constants (TINT_WHITE = 0, TINT_GREEN = 1, TINT_AMBER = 2, TINT_CUSTOM = 3) and the three fixed RGB coefficient triples in a shared package, grey_colorize_pkg.
REQ-033 SHALL implement the per-channel multiply-and-shift stage as one sub-module, grey_chan_mul, instantiated three times.

Verification
REQ-034 SHALL cover the white tint: luma = 200 with i_ce always 1 -> RGB = (200,200,200) exactly 2 cycles later, and o_hs and o_vs delayed by 2.
REQ-035 SHALL cover the amber tint: luma = 255 -> (255,176,0); luma = 128 -> (128,88,0).
REQ-036 SHALL cover blanking: i_blank = 1 with luma = 255 -> RGB = 0 with o_blank = 1.
REQ-037 SHALL cover a mid-frame custom write of (10,20,30) while custom is selected:
- o_tint_pend = 1 and output unchanged;
- after the i_vs rising edge, luma = 255 -> (10,20,30) and o_tint_pend = 0.
REQ-038 SHALL cover clock-enable stalls: i_ce toggling 1-of-3 -> outputs change only on i_ce cycles, latency 2 i_ce cycles.
REQ-039 SHALL cover asynchronous reset mid-line: all outputs 0 immediately and tint = RESET_TINT; with GREY_COLORIZE_SCANLINE_EN and i_scanline = 1, line 1 with luma = 200 and the white tint -> 100.
